gauss_blur3x3: RTL and testbench

//  Upstream stage of the difference-of-Gaussians pipeline. Reads a raster image from a source RAM,

---
 rtl/dog_pkg.sv | 24 ++
 rtl/gauss_line_buf.sv | 29 ++
 rtl/gauss_blur3x3.sv | 197 +++++++++++++++++++
 tb/tb_gauss_blur3x3.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dog_pkg.sv
// dog_pkg - definitions shared by the difference-of-Gaussians pipeline stages.
//   Default image geometry and bus widths, the 3x3 Gaussian kernel weights
//   [1 2 1; 2 4 2; 1 2 1] with their normalising shift, and the frame FSM
//   state encoding.
package dog_pkg;

  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 16;

  // The kernel weights sum to 16, so the normalising divide is a right shift by 4.
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;
  localparam int K_SHIFT  = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/gauss_line_buf.sv
// gauss_line_buf - one image row of pixel storage, single-port, read-before-write.
//   clk      in   clock
//   en       in   access strobe: read old word and write new word at addr
//   addr     in   column index
//   wr_data  in   word stored at addr
//   rd_data  out  previous content of addr, registered (valid the cycle after en)
// Contents are not reset; they are always overwritten before use.
module gauss_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [ABITS-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      rd_data   <= mem[addr];
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/gauss_blur3x3.sv
// gauss_blur3x3 - 3x3 Gaussian blur of a raster frame, source RAM to destination RAM.
//   clk, rst       clock; asynchronous active-high reset
//   start          frame start pulse, honoured only when idle
//   src_rd_valid   read strobe to the source RAM (every cycle while reading)
//   src_rd_addr    raster read address 0..IMG_W*IMG_H-1
//   src_valid_in   returned pixel strobe (any latency, in order)
//   src_data_in    returned pixel
//   dst_wr_valid   destination write strobe (interior pixels only)
//   dst_wr_addr    destination write address
//   dst_wr_data    blurred pixel
//   busy           frame in progress (READ/DRAIN)
//   done           one-cycle pulse after the last write
// Build option: define GAUSS_ROUND_EN for round-half-up; otherwise the
// normalising shift truncates.
module gauss_blur3x3 #(
  parameter int IMG_W = dog_pkg::DEF_IMG_W,
  parameter int IMG_H = dog_pkg::DEF_IMG_H,
  parameter int DW    = dog_pkg::DEF_DW,
  parameter int AW    = dog_pkg::DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          src_rd_valid,
  output logic [AW-1:0] src_rd_addr,
  input  logic          src_valid_in,
  input  logic [DW-1:0] src_data_in,
  output logic          dst_wr_valid,
  output logic [AW-1:0] dst_wr_addr,
  output logic [DW-1:0] dst_wr_data,
  output logic          busy,
  output logic          done
);
  import dog_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = DW + K_SHIFT;
  localparam logic [AW-1:0] LAST_RD = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] LAST_WR = AW'((IMG_H - 2) * IMG_W + IMG_W - 2);
  localparam logic [CW-1:0] C_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_MAX   = RW'(IMG_H - 1);

  state_t        state_reg;
  logic [AW-1:0] rd_addr_reg;
  logic [CW-1:0] c_reg;
  logic [RW-1:0] r_reg;
  logic          in_full_reg;
  logic          acc;
  logic          out_gate;
  logic [AW-1:0] wr_addr_calc;

  // Stage 1: the accepted beat, delayed while lb0 is read.
  logic          acc_d1_reg, wr_d1_reg;
  logic [AW-1:0] addr_d1_reg;
  logic [CW-1:0] c_d1_reg;
  logic [DW-1:0] pix_d1_reg;
  // Stage 2: the newest window column, complete once lb1 has been read.
  logic          acc_d2_reg;
  logic [DW-1:0] pix_d2_reg, mid_d2_reg;
  logic [DW-1:0] lb0_q, lb1_q;

  logic [DW-1:0] col_new [0:2];
  logic [DW-1:0] win_c2  [0:2];
  logic [DW-1:0] win_c1  [0:2];
  logic [SW-1:0] sum, rnd;

  assign src_rd_valid = (state_reg == READ);
  assign src_rd_addr  = rd_addr_reg;
  assign busy         = (state_reg == READ) || (state_reg == DRAIN);
  assign done         = (state_reg == DONE);

  // Beats past the last pixel of the frame, or outside READ/DRAIN, are dropped.
  assign acc = src_valid_in && busy && !in_full_reg;
  assign out_gate = (r_reg >= RW'(2)) && (c_reg >= CW'(2));
  assign wr_addr_calc = (AW'(r_reg) - AW'(1)) * AW'(IMG_W) + (AW'(c_reg) - AW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          state_reg   <= READ;
          rd_addr_reg <= '0;
        end
        READ: if (rd_addr_reg == LAST_RD) begin
          state_reg   <= DRAIN;
          rd_addr_reg <= '0;
        end else begin
          rd_addr_reg <= rd_addr_reg + AW'(1);
        end
        DRAIN: if (dst_wr_valid && (dst_wr_addr == LAST_WR)) state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg       <= '0;
      r_reg       <= '0;
      in_full_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start) begin
      c_reg       <= '0;
      r_reg       <= '0;
      in_full_reg <= 1'b0;
    end else if (acc) begin
      if (c_reg == C_MAX) begin
        c_reg <= '0;
        if (r_reg == R_MAX) in_full_reg <= 1'b1;
        else                r_reg       <= r_reg + RW'(1);
      end else begin
        c_reg <= c_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_d1_reg   <= 1'b0;
      wr_d1_reg    <= 1'b0;
      addr_d1_reg  <= '0;
      c_d1_reg     <= '0;
      pix_d1_reg   <= '0;
      acc_d2_reg   <= 1'b0;
      dst_wr_valid <= 1'b0;
      dst_wr_addr  <= '0;
      pix_d2_reg   <= '0;
      mid_d2_reg   <= '0;
    end else begin
      acc_d1_reg   <= acc;
      wr_d1_reg    <= acc && out_gate;
      if (acc) begin
        addr_d1_reg <= wr_addr_calc;
        c_d1_reg    <= c_reg;
        pix_d1_reg  <= src_data_in;
      end
      acc_d2_reg   <= acc_d1_reg;
      dst_wr_valid <= wr_d1_reg;
      if (acc_d1_reg) begin
        pix_d2_reg <= pix_d1_reg;
        mid_d2_reg <= lb0_q;
      end
      if (wr_d1_reg) dst_wr_addr <= addr_d1_reg;
    end
  end

  // lb0 holds row r-1; its read-out is passed one cycle later into lb1, which
  // therefore holds row r-2. Each buffer sees exactly one address per cycle.
  gauss_line_buf #(.DEPTH(IMG_W), .WIDTH(DW), .ABITS(CW)) u_lb0 (
    .clk(clk), .en(acc), .addr(c_reg), .wr_data(src_data_in), .rd_data(lb0_q)
  );
  gauss_line_buf #(.DEPTH(IMG_W), .WIDTH(DW), .ABITS(CW)) u_lb1 (
    .clk(clk), .en(acc_d1_reg), .addr(c_d1_reg), .wr_data(lb0_q), .rd_data(lb1_q)
  );

  // Row 0 = image row r-2 (top), 1 = r-1, 2 = r (bottom). The newest column
  // feeds the sum directly; the two older columns live in win_c2/win_c1.
  assign col_new[0] = lb1_q;
  assign col_new[1] = mid_d2_reg;
  assign col_new[2] = pix_d2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      logic [DW-1:0] c2_reg, c1_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          c2_reg <= '0;
          c1_reg <= '0;
        end else if (acc_d2_reg) begin
          c2_reg <= c1_reg;
          c1_reg <= col_new[gi];
        end
      end
      assign win_c2[gi] = c2_reg;
      assign win_c1[gi] = c1_reg;
    end
  endgenerate

  always_comb begin
    sum = SW'(K_CORNER) * (SW'(win_c2[0]) + SW'(col_new[0]) + SW'(win_c2[2]) + SW'(col_new[2]))
        + SW'(K_EDGE)   * (SW'(win_c1[0]) + SW'(win_c1[2]) + SW'(win_c2[1]) + SW'(col_new[1]))
        + SW'(K_CENTRE) * SW'(win_c1[1]);
`ifdef GAUSS_ROUND_EN
    rnd = sum + SW'(1 << (K_SHIFT - 1));
`else
    rnd = sum;
`endif
  end

  // The weights sum to 16, so the shifted result always fits in DW bits.
  assign dst_wr_data = dst_wr_valid ? rnd[SW-1:K_SHIFT] : '0;

endmodule

// File: tb/tb_gauss_blur3x3.sv
// tb_gauss_blur3x3 - self-checking bench for gauss_blur3x3 on a 4x4 frame.
// A source-RAM model with configurable latency and optional gaps feeds the
// DUT; a reference blur computed directly from the image predicts every write.
module tb_gauss_blur3x3;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int EXP_N = (W - 2) * (H - 2);
`ifdef GAUSS_ROUND_EN
  localparam int IMP_C = 64, IMP_E = 32, IMP_K = 16;
`else
  localparam int IMP_C = 63, IMP_E = 31, IMP_K = 15;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        src_rd_valid;
  logic [15:0] src_rd_addr;
  logic        src_valid_in = 1'b0;
  logic [7:0]  src_data_in = '0;
  logic        dst_wr_valid;
  logic [15:0] dst_wr_addr;
  logic [7:0]  dst_wr_data;
  logic        busy, done;

  gauss_blur3x3 #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_rd_valid(src_rd_valid), .src_rd_addr(src_rd_addr),
    .src_valid_in(src_valid_in), .src_data_in(src_data_in),
    .dst_wr_valid(dst_wr_valid), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int rdy; } beat_t;
  typedef struct { int addr; int data; } exp_t;

  logic [7:0] img [0:NPIX-1];
  beat_t sq[$];
  exp_t  exp_q[$];
  int    cap [0:NPIX-1];
  int    ref_cap [0:NPIX-1];
  int    cyc = 0, lat = 1, src_beats = 0;
  bit    gaps = 0;
  int    rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int    n_pass = 0, n_total = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference blur: weight of neighbour (dy,dx) is (2-|dy|)*(2-|dx|).
  task automatic build_expected();
    exp_t e;
    int s, ady, adx;
    exp_q.delete();
    for (int y = 1; y < H - 1; y++)
      for (int x = 1; x < W - 1; x++) begin
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            ady = (dy < 0) ? -dy : dy;
            adx = (dx < 0) ? -dx : dx;
            s += (2 - ady) * (2 - adx) * int'(img[(y + dy) * W + x + dx]);
          end
        e.addr = y * W + x;
`ifdef GAUSS_ROUND_EN
        e.data = (s + 8) / 16;
`else
        e.data = s / 16;
`endif
        exp_q.push_back(e);
      end
  endtask

  // Source RAM: requests seen on one negedge are answered from lat negedges later.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) sq.delete();
      else if (src_rd_valid) begin
        b.d   = (int'(src_rd_addr) < NPIX) ? img[src_rd_addr] : 8'd0;
        b.rdy = cyc + lat;
        sq.push_back(b);
      end
      src_valid_in = 1'b0;
      src_data_in  = '0;
      if (!rst && sq.size() > 0 && sq[0].rdy <= cyc && (!gaps || $urandom_range(0, 2) != 0)) begin
        src_valid_in = 1'b1;
        src_data_in  = sq[0].d;
        void'(sq.pop_front());
        src_beats++;
      end
    end
  end

  // Compare process: reads must be sequential, writes must match the model in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (src_rd_valid) begin
          chk(int'(src_rd_addr) == rd_cnt, "rd_addr", int'(src_rd_addr), rd_cnt);
          rd_cnt++;
        end
        if (dst_wr_valid) begin
          $display("write addr=%0d data=%0d", dst_wr_addr, dst_wr_data);
          if (exp_q.size() == 0) chk(1'b0, "unexpected_write", int'(dst_wr_addr), -1);
          else begin
            e = exp_q.pop_front();
            chk(int'(dst_wr_addr) == e.addr, "wr_addr", int'(dst_wr_addr), e.addr);
            chk(int'(dst_wr_data) == e.data, "wr_data", int'(dst_wr_data), e.data);
          end
          if (int'(dst_wr_addr) < NPIX) cap[dst_wr_addr] = int'(dst_wr_data);
          wr_cnt++;
        end
        if (done) begin
          chk(exp_q.size() == 0, "done_after_last_write", exp_q.size(), 0);
          chk(wr_cnt == EXP_N, "writes_at_done", wr_cnt, EXP_N);
          done_cnt++;
        end
      end
    end
  end

  task automatic run_frame(input int l, input bit g, input bit restart, input bit abort);
    bit drain_pulsed;
    lat = l; gaps = g;
    build_expected();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; src_beats = 0;
    for (int i = 0; i < NPIX; i++) cap[i] = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
    if (abort) begin
      for (int k = 0; k < 500 && src_beats < 10; k++) @(negedge clk);
      chk(src_beats >= 10, "beats_before_rst", src_beats, 10);
      #2 rst = 1'b1;
      #1;
      chk({src_rd_valid, dst_wr_valid, busy, done} == 4'b0, "outputs_zero_in_rst",
          int'({src_rd_valid, dst_wr_valid, busy, done}), 0);
      chk(src_rd_addr == 16'd0 && dst_wr_addr == 16'd0 && dst_wr_data == 8'd0,
          "buses_zero_in_rst", int'(src_rd_addr) + int'(dst_wr_addr) + int'(dst_wr_data), 0);
      exp_q.delete();
      @(negedge clk); @(negedge clk); rst = 1'b0;
      repeat (30) @(negedge clk);
      chk(wr_cnt == 0, "no_write_after_rst", wr_cnt, 0);
      chk(done_cnt == 0, "no_done_after_rst", done_cnt, 0);
      return;
    end
    drain_pulsed = 0;
    for (int k = 0; k < 1000 && done_cnt == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && k == 3) start = 1'b1;
      if (restart && !drain_pulsed && busy && !src_rd_valid) begin
        start = 1'b1;
        drain_pulsed = 1;
      end
    end
    start = 1'b0;
    chk(done_cnt != 0, "done_timeout", done_cnt, 1);
    if (restart) chk(drain_pulsed, "start_in_drain_applied", int'(drain_pulsed), 1);
    repeat (8) @(negedge clk);
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(wr_cnt == EXP_N, "write_count", wr_cnt, EXP_N);
    chk(rd_cnt == NPIX, "read_count", rd_cnt, NPIX);
    chk(busy == 1'b0, "idle_after_frame", int'(busy), 0);
  endtask

  task automatic check_const(input string name, input int v);
    chk(cap[5] == v, name, cap[5], v);
    chk(cap[6] == v, name, cap[6], v);
    chk(cap[9] == v, name, cap[9], v);
    chk(cap[10] == v, name, cap[10], v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk({src_rd_valid, dst_wr_valid, busy, done} == 4'b0, "reset_flags",
        int'({src_rd_valid, dst_wr_valid, busy, done}), 0);
    chk(src_rd_addr == 16'd0 && dst_wr_addr == 16'd0 && dst_wr_data == 8'd0,
        "reset_buses", int'(src_rd_addr) + int'(dst_wr_addr) + int'(dst_wr_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: constant 100
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    run_frame(1, 0, 0, 0);
    check_const("const100", 100);

    // 2: impulse 255 at (1,1)
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    img[5] = 8'd255;
    run_frame(1, 0, 0, 0);
    chk(cap[5] == IMP_C, "impulse_centre", cap[5], IMP_C);
    chk(cap[6] == IMP_E, "impulse_edge6", cap[6], IMP_E);
    chk(cap[9] == IMP_E, "impulse_edge9", cap[9], IMP_E);
    chk(cap[10] == IMP_K, "impulse_corner", cap[10], IMP_K);

    // 3: all 255
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    run_frame(1, 0, 0, 0);
    check_const("all255", 255);

    // 4: random image, gap-free then gapped with 3-cycle latency
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame(1, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) ref_cap[i] = cap[i];
    run_frame(3, 1, 0, 0);
    for (int a = 5; a <= 10; a++)
      if ((a % W) != 0 && (a % W) != W - 1) chk(cap[a] == ref_cap[a], "gap_vs_nogap", cap[a], ref_cap[a]);

    // 5: start pulses during READ and DRAIN are ignored
    for (int i = 0; i < NPIX; i++) img[i] = 8'((i * 37 + 11) % 256);
    run_frame(1, 0, 1, 0);

    // 6: reset mid-frame, then a clean frame
    run_frame(1, 0, 0, 1);
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    run_frame(1, 0, 0, 0);
    check_const("const100_after_rst", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
